cp0_exc_ctrl: RTL and testbench

- Exception/interrupt sequencer for the CP0 register block at the pipeline commit (MEM) stage.
- Arbitrates between pending interrupts, synchronous exceptions and ERET, then drives one CP0 write cycle: the per-register write enables plus EPC, BadVAddr, Cause and Status fields.
- Flushes the pipeline, stalls fetch, and issues a single-cycle PC redirect to the exception vector or to EPC.

---
 rtl/cp0_exc_ctrl.sv | 163 ++++++++++++++++
 tb/tb_cp0_exc_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_exc_ctrl.sv
// rtl/cp0_exc_ctrl.sv - CP0 exception/interrupt/ERET sequencer at the commit stage
//
// Arbitrates interrupt > exception > ERET on a valid commit, then runs a
// fixed three-state sequence: IDLE -> WRITE (one CP0 write cycle, flush) ->
// REDIRECT (one-cycle PC redirect) -> IDLE.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   commit_*                 committing instruction: valid, pc, delay-slot flag
//   exc_valid/code/badvaddr  synchronous exception raised by that instruction
//   eret_valid               committing instruction is ERET
//   hw_int, timer_int, sw_int  interrupt sources forming Cause.IP
//   status_in, epc_in        current CP0 Status and EPC
//   cp0_we                   per-register write enables (8 BadVAddr, 12 Status,
//                            13 Cause, 14 EPC), asserted only in WRITE
//   cp0_epc .. cp0_ie        write data for the CP0 fields
//   flush, stall             pipeline control
//   redirect_valid/pc        single-cycle fetch redirect
//   int_pending              combinational enabled-interrupt indication
module cp0_exc_ctrl #(
    parameter int                 WIDTH      = 32,
    parameter logic [WIDTH-1:0]   EXC_VECTOR = 32'hBFC00380
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             commit_valid,
    input  logic [WIDTH-1:0] commit_pc,
    input  logic             commit_bd,
    input  logic             exc_valid,
    input  logic [4:0]       exc_code,
    input  logic [WIDTH-1:0] exc_badvaddr,
    input  logic             eret_valid,
    input  logic [5:0]       hw_int,
    input  logic             timer_int,
    input  logic [1:0]       sw_int,
    input  logic [WIDTH-1:0] status_in,
    input  logic [WIDTH-1:0] epc_in,
    output logic [WIDTH-1:0] cp0_we,
    output logic [WIDTH-1:0] cp0_epc,
    output logic [WIDTH-1:0] cp0_badvaddr,
    output logic [4:0]       cp0_exc_code,
    output logic             cp0_bd,
    output logic [7:0]       cp0_int_en,
    output logic             cp0_exl,
    output logic             cp0_ie,
    output logic             flush,
    output logic             stall,
    output logic             redirect_valid,
    output logic [WIDTH-1:0] redirect_pc,
    output logic             int_pending
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WRITE    = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic             eret_q;
    logic [4:0]       code_q;
    logic [WIDTH-1:0] pc_q;
    logic             bd_q;
    logic [WIDTH-1:0] badvaddr_q;
    logic [7:0]       im_q;
    logic             ie_q;
    logic             exl_q;
    logic [WIDTH-1:0] epc_q;

    logic [7:0] ip;
    logic       hit;

    // Only IE, EXL and IM of Status matter here.
    logic unused_status;
    assign unused_status = ^{status_in[WIDTH-1:16], status_in[7:2]};

    // Timer shares IP7 with the top hardware line.
    assign ip          = {hw_int[5] | timer_int, hw_int[4:0], sw_int};
    assign int_pending = status_in[0] & ~status_in[1] & (|(ip & status_in[15:8]));
    assign hit         = commit_valid & (int_pending | exc_valid | eret_valid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eret_q     <= 1'b0;
            code_q     <= '0;
            pc_q       <= '0;
            bd_q       <= 1'b0;
            badvaddr_q <= '0;
            im_q       <= '0;
            ie_q       <= 1'b0;
            exl_q      <= 1'b0;
            epc_q      <= '0;
        end else if (state == IDLE && hit) begin
            // Interrupt outranks exception, which outranks ERET.
            eret_q     <= ~int_pending & ~exc_valid;
            code_q     <= (~int_pending & exc_valid) ? exc_code : 5'd0;
            pc_q       <= commit_pc;
            bd_q       <= commit_bd;
            badvaddr_q <= exc_badvaddr;
            im_q       <= status_in[15:8];
            ie_q       <= status_in[0];
            exl_q      <= status_in[1];
            epc_q      <= epc_in;
        end
    end

    always_comb begin
        state_next     = state;
        cp0_we         = '0;
        flush          = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        case (state)
            IDLE: begin
                if (hit) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                flush      = 1'b1;
                stall      = 1'b1;
                cp0_we[12] = 1'b1;
                if (!eret_q) begin
                    cp0_we[13] = 1'b1;
                    // A nested exception must keep the original EPC.
                    cp0_we[14] = ~exl_q;
                    // Interrupts latch code 0, so BadVAddr is only written for AdEL/AdES.
                    cp0_we[8]  = (code_q == 5'd4) || (code_q == 5'd5);
                end
                state_next = REDIRECT;
            end
            REDIRECT: begin
                stall          = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = eret_q ? epc_q : EXC_VECTOR;
                state_next     = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign cp0_epc      = pc_q;
    assign cp0_badvaddr = badvaddr_q;
    assign cp0_exc_code = code_q;
    assign cp0_bd       = bd_q;
    assign cp0_int_en   = im_q;
    assign cp0_ie       = ie_q;
    assign cp0_exl      = (state == WRITE) & ~eret_q;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// tb/tb_cp0_exc_ctrl.sv - self-checking bench for cp0_exc_ctrl
module tb_cp0_exc_ctrl;

    localparam logic [31:0] VEC = 32'hBFC00380;

    logic        clk;
    logic        rst;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic        commit_bd;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_badvaddr;
    logic        eret_valid;
    logic [5:0]  hw_int;
    logic        timer_int;
    logic [1:0]  sw_int;
    logic [31:0] status_in;
    logic [31:0] epc_in;
    logic [31:0] cp0_we;
    logic [31:0] cp0_epc;
    logic [31:0] cp0_badvaddr;
    logic [4:0]  cp0_exc_code;
    logic        cp0_bd;
    logic [7:0]  cp0_int_en;
    logic        cp0_exl;
    logic        cp0_ie;
    logic        flush;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        int_pending;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic        cv;
        logic [31:0] pc;
        logic        bd;
        logic        ev;
        logic [4:0]  code;
        logic [31:0] bva;
        logic        er;
        logic [5:0]  hw;
        logic        tmr;
        logic [1:0]  sw;
        logic [31:0] st;
        logic [31:0] epc;
    } vec_t;

    vec_t vq[$];

    cp0_exc_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .commit_valid   (commit_valid),
        .commit_pc      (commit_pc),
        .commit_bd      (commit_bd),
        .exc_valid      (exc_valid),
        .exc_code       (exc_code),
        .exc_badvaddr   (exc_badvaddr),
        .eret_valid     (eret_valid),
        .hw_int         (hw_int),
        .timer_int      (timer_int),
        .sw_int         (sw_int),
        .status_in      (status_in),
        .epc_in         (epc_in),
        .cp0_we         (cp0_we),
        .cp0_epc        (cp0_epc),
        .cp0_badvaddr   (cp0_badvaddr),
        .cp0_exc_code   (cp0_exc_code),
        .cp0_bd         (cp0_bd),
        .cp0_int_en     (cp0_int_en),
        .cp0_exl        (cp0_exl),
        .cp0_ie         (cp0_ie),
        .flush          (flush),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .int_pending    (int_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mkv(input logic cv, input logic [31:0] pc, input logic bd,
                                 input logic ev, input logic [4:0] code, input logic [31:0] bva,
                                 input logic er, input logic [5:0] hw, input logic tmr,
                                 input logic [1:0] sw, input logic [31:0] st, input logic [31:0] epc);
        vec_t v;
        v.cv = cv; v.pc = pc; v.bd = bd; v.ev = ev; v.code = code; v.bva = bva;
        v.er = er; v.hw = hw; v.tmr = tmr; v.sw = sw; v.st = st; v.epc = epc;
        return v;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        v.cv   = ($urandom_range(0, 3) != 0);
        v.pc   = $urandom & 32'hFFFF_FFFC;
        v.bd   = $urandom_range(0, 1);
        v.ev   = $urandom_range(0, 1);
        v.code = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(4, 5)) : 5'($urandom_range(0, 31));
        v.bva  = $urandom;
        v.er   = $urandom_range(0, 1);
        v.hw   = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
        v.tmr  = ($urandom_range(0, 4) == 0);
        v.sw   = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'd0;
        v.st   = $urandom;
        v.epc  = $urandom;
        return v;
    endfunction

    // Enabled-interrupt rule: some IP line with its IM bit set, IE=1, EXL=0.
    function automatic bit model_pending(input vec_t v);
        int ip;
        int im;
        ip = (v.sw) + (v.hw[4:0] * 4) + ((v.hw[5] || v.tmr) ? 128 : 0);
        im = (v.st >> 8) & 255;
        return (v.st[0] == 1'b1) && (v.st[1] == 1'b0) && ((ip & im) != 0);
    endfunction

    task automatic drive(input vec_t v);
        commit_valid = v.cv;
        commit_pc    = v.pc;
        commit_bd    = v.bd;
        exc_valid    = v.ev;
        exc_code     = v.code;
        exc_badvaddr = v.bva;
        eret_valid   = v.er;
        hw_int       = v.hw;
        timer_int    = v.tmr;
        sw_int       = v.sw;
        status_in    = v.st;
        epc_in       = v.epc;
    endtask

    task automatic test_reset();
        drive(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if ({cp0_we, flush, stall, redirect_valid, redirect_pc} !== '0)
            $display("FAIL reset_ctrl: we=%h flush=%b stall=%b rv=%b rpc=%h, required all 0",
                     cp0_we, flush, stall, redirect_valid, redirect_pc);
        else pass_cnt++;
        total_cnt++;
        if ({cp0_epc, cp0_badvaddr, cp0_exc_code, cp0_bd, cp0_int_en, cp0_exl, cp0_ie} !== '0)
            $display("FAIL reset_fields: epc=%h bva=%h code=%h bd=%b im=%h exl=%b ie=%b, required all 0",
                     cp0_epc, cp0_badvaddr, cp0_exc_code, cp0_bd, cp0_int_en, cp0_exl, cp0_ie);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Runs every queued commit through the model and checks the full sequence.
    task automatic test_commit_sequences(input string tag);
        vec_t        v;
        bit          pend;
        int          kind;
        logic [4:0]  ecode;
        logic [31:0] ewe;
        logic [31:0] erpc;
        while (vq.size() > 0) begin
            v = vq.pop_front();
            @(negedge clk);
            drive(v);
            #1;
            pend = model_pending(v);
            total_cnt++;
            if (int_pending !== pend)
                $display("FAIL %s int_pending: got %b want %b", tag, int_pending, pend);
            else pass_cnt++;

            kind  = 0;
            ecode = 5'd0;
            if (v.cv) begin
                if (pend) kind = 1;
                else if (v.ev) begin kind = 1; ecode = v.code; end
                else if (v.er) kind = 2;
            end

            @(posedge clk);
            #1;
            if (kind == 0) begin
                total_cnt++;
                if (cp0_we !== 0 || flush !== 1'b0 || stall !== 1'b0 || redirect_valid !== 1'b0)
                    $display("FAIL %s idle_no_hit: we=%h flush=%b stall=%b rv=%b, required 0",
                             tag, cp0_we, flush, stall, redirect_valid);
                else pass_cnt++;
                continue;
            end

            if (kind == 2) ewe = 32'h1 << 12;
            else begin
                ewe = (32'h1 << 12) | (32'h1 << 13);
                if (!v.st[1]) ewe = ewe | (32'h1 << 14);
                if (ecode == 5'd4 || ecode == 5'd5) ewe = ewe | (32'h1 << 8);
            end
            erpc = (kind == 2) ? v.epc : VEC;

            total_cnt++;
            if (cp0_we !== ewe)
                $display("FAIL %s write_we: got %h want %h", tag, cp0_we, ewe);
            else pass_cnt++;
            total_cnt++;
            if (flush !== 1'b1 || stall !== 1'b1 || redirect_valid !== 1'b0)
                $display("FAIL %s write_ctrl: flush=%b stall=%b rv=%b, want 1 1 0",
                         tag, flush, stall, redirect_valid);
            else pass_cnt++;
            total_cnt++;
            if (cp0_epc !== v.pc || cp0_bd !== v.bd)
                $display("FAIL %s write_epc_bd: got %h/%b want %h/%b", tag, cp0_epc, cp0_bd, v.pc, v.bd);
            else pass_cnt++;
            total_cnt++;
            if (cp0_exl !== (kind == 1) || cp0_ie !== v.st[0] || cp0_int_en !== v.st[15:8])
                $display("FAIL %s write_status: exl/ie/im got %b/%b/%h want %b/%b/%h", tag,
                         cp0_exl, cp0_ie, cp0_int_en, (kind == 1), v.st[0], v.st[15:8]);
            else pass_cnt++;
            if (kind == 1) begin
                total_cnt++;
                if (cp0_exc_code !== ecode)
                    $display("FAIL %s write_code: got %0d want %0d", tag, cp0_exc_code, ecode);
                else pass_cnt++;
                if (ecode == 5'd4 || ecode == 5'd5) begin
                    total_cnt++;
                    if (cp0_badvaddr !== v.bva)
                        $display("FAIL %s write_bva: got %h want %h", tag, cp0_badvaddr, v.bva);
                    else pass_cnt++;
                end
            end

            // Commit traffic during WRITE/REDIRECT must be ignored.
            @(negedge clk);
            v = rand_vec();
            v.cv = 1'b1;
            v.ev = 1'b1;
            drive(v);
            @(posedge clk);
            #1;
            total_cnt++;
            if (redirect_valid !== 1'b1 || redirect_pc !== erpc)
                $display("FAIL %s redirect: rv=%b pc=%h want 1 %h", tag, redirect_valid, redirect_pc, erpc);
            else pass_cnt++;
            total_cnt++;
            if (cp0_we !== 0 || flush !== 1'b0 || stall !== 1'b1)
                $display("FAIL %s redirect_ctrl: we=%h flush=%b stall=%b want 0 0 1",
                         tag, cp0_we, flush, stall);
            else pass_cnt++;

            @(negedge clk);
            drive(v);
            @(posedge clk);
            #1;
            total_cnt++;
            if (cp0_we !== 0 || flush !== 1'b0 || stall !== 1'b0 || redirect_valid !== 1'b0)
                $display("FAIL %s back_idle: we=%h flush=%b stall=%b rv=%b want 0",
                         tag, cp0_we, flush, stall, redirect_valid);
            else pass_cnt++;
        end
    endtask

    task automatic test_directed();
        vq.push_back(mkv(1, 32'hBFC00100, 0, 1, 5'd4, 32'h3, 0, 0, 0, 0, 32'h0000FF01, 0));
        vq.push_back(mkv(1, 32'hBFC00204, 1, 1, 5'd8, 32'h3, 0, 0, 0, 0, 32'h0000FF01, 0));
        vq.push_back(mkv(1, 32'hBFC00300, 0, 1, 5'd10, 32'h44, 0, 0, 1, 0, 32'h00008001, 0));
        vq.push_back(mkv(1, 32'hBFC00400, 0, 0, 5'd0, 0, 0, 0, 1, 0, 32'h0000FF03, 0));
        vq.push_back(mkv(1, 32'hBFC00404, 0, 1, 5'd12, 0, 0, 0, 1, 0, 32'h0000FF03, 0));
        vq.push_back(mkv(1, 32'hBFC00408, 0, 0, 5'd0, 0, 1, 0, 0, 0, 32'h0000FF03, 32'hBFC00500));
        vq.push_back(mkv(1, 32'h80001000, 0, 1, 5'd5, 32'h1235, 1, 0, 0, 0, 32'h0, 32'h1234));
        vq.push_back(mkv(0, 32'h80002000, 0, 1, 5'd4, 32'h9, 1, 6'h3F, 1, 3, 32'h0000FF01, 0));
        test_commit_sequences("directed");
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) vq.push_back(rand_vec());
        test_commit_sequences("random");
    endtask

    task automatic test_reset_mid_write();
        vec_t v;
        v = mkv(1, 32'hBFC00100, 0, 1, 5'd4, 32'h3, 0, 0, 0, 0, 32'h0000FF01, 0);
        @(negedge clk);
        drive(v);
        @(posedge clk);
        #1;
        total_cnt++;
        if (flush !== 1'b1)
            $display("FAIL rst_mid_enter_write: flush=%b want 1", flush);
        else pass_cnt++;
        #2;
        rst = 1'b1;
        #1;
        total_cnt++;
        if (cp0_we !== 0 || flush !== 1'b0 || stall !== 1'b0)
            $display("FAIL rst_mid_async: we=%h flush=%b stall=%b want 0", cp0_we, flush, stall);
        else pass_cnt++;
        @(negedge clk);
        drive(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        total_cnt++;
        if (redirect_valid !== 1'b0 || redirect_pc !== 0 || stall !== 1'b0)
            $display("FAIL rst_mid_no_redirect: rv=%b pc=%h stall=%b want 0", redirect_valid, redirect_pc, stall);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        v.code = 5'd5;
        drive(v);
        @(posedge clk);
        #1;
        total_cnt++;
        if (cp0_we !== 32'h0000_7100 || cp0_exc_code !== 5'd5)
            $display("FAIL rst_mid_reaccept: we=%h code=%0d want 00007100 5", cp0_we, cp0_exc_code);
        else pass_cnt++;
        @(negedge clk);
        drive(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        total_cnt++;
        if (redirect_valid !== 1'b1 || redirect_pc !== VEC)
            $display("FAIL rst_mid_redirect: rv=%b pc=%h want 1 %h", redirect_valid, redirect_pc, VEC);
        else pass_cnt++;
        @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_mid_write();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
